// File: rtl/rb_uart_bus_master.sv
// rb_uart_bus_master
//   Turns a byte-framed command stream from a UART receiver into single
//   register-bus cycles. It answers every command with one byte to the UART
//   transmitter over a valid/ready handshake.
//     write frame: 0x57, addr, data -> bus write, reply 0x06 (ACK)
//     read frame : 0x52, addr       -> bus read,  reply read byte
//     other cmd  :                  -> reply 0x15 (NAK), error counted
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     rx_data, rx_valid          received byte with its one-cycle strobe
//     tx_data, tx_valid, tx_ready response byte and its handshake
//     address, data_write_in     register-bus address and write data
//     data_read_out              register-bus read data (1-cycle latency)
//     reg_en, write_en           bus cycle strobe and write qualifier
//     busy                       high whenever a command is in progress
//     err_cnt                    saturating protocol-error count
module rb_uart_bus_master #(
    parameter int ADR_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [ADR_BITS-1:0] address,
    output logic [7:0]          data_write_in,
    input  logic [7:0]          data_read_out,
    output logic                reg_en,
    output logic                write_en,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Counter only has to hold TIMEOUT_CYCLES-1: the cycle that would reach
    // TIMEOUT_CYCLES is the one that aborts the frame.
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        SEND
    } state_t;

    state_t         state, state_nxt;
    logic           is_rd, is_rd_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit, tmo_run;
    logic           ld_addr, ld_data, ld_tx, err_inc;
    logic [7:0]     tx_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        is_rd_nxt = is_rd;
        ld_addr   = 1'b0;
        ld_data   = 1'b0;
        ld_tx     = 1'b0;
        tx_nxt    = tx_data;
        err_inc   = 1'b0;
        tmo_run   = 1'b0;
        reg_en    = 1'b0;
        write_en  = 1'b0;
        tx_valid  = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR) begin
                        is_rd_nxt = 1'b0;
                        state_nxt = GET_ADDR;
                    end else if (rx_data == CMD_RD) begin
                        is_rd_nxt = 1'b1;
                        state_nxt = GET_ADDR;
                    end else begin
                        ld_tx     = 1'b1;
                        tx_nxt    = RSP_NAK;
                        err_inc   = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            // A byte arriving in the timeout cycle wins over the abort.
            GET_ADDR: begin
                if (rx_valid) begin
                    ld_addr   = 1'b1;
                    state_nxt = is_rd ? RD_ISSUE : GET_DATA;
                end else if (tmo_hit) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    ld_data   = 1'b1;
                    state_nxt = WR_ISSUE;
                end else if (tmo_hit) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            // In the remaining states any received byte is an overrun and is dropped.
            WR_ISSUE: begin
                reg_en    = 1'b1;
                write_en  = 1'b1;
                ld_tx     = 1'b1;
                tx_nxt    = RSP_ACK;
                err_inc   = rx_valid;
                state_nxt = SEND;
            end
            RD_ISSUE: begin
                reg_en    = 1'b1;
                err_inc   = rx_valid;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                ld_tx     = 1'b1;
                tx_nxt    = data_read_out;
                err_inc   = rx_valid;
                state_nxt = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                err_inc  = rx_valid;
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_rd         <= 1'b0;
            address       <= '0;
            data_write_in <= 8'h00;
            tx_data       <= 8'h00;
            err_cnt       <= 8'h00;
            tmo_cnt       <= '0;
        end else begin
            is_rd <= is_rd_nxt;
            if (ld_addr) begin
                address <= rx_data[ADR_BITS-1:0];
            end
            if (ld_data) begin
                data_write_in <= rx_data;
            end
            if (ld_tx) begin
                tx_data <= tx_nxt;
            end
            if (err_inc) begin
                err_cnt <= sat_inc(err_cnt);
            end
            // Cleared on accepted bytes, on abort and everywhere outside GET_*.
            tmo_cnt <= tmo_run ? tmo_cnt + TW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_rb_uart_bus_master.sv
// tb_rb_uart_bus_master
//   Directed bench for rb_uart_bus_master: a table of complete frames with
//   hand-computed replies, followed by hand-written sequences for timeout,
//   overrun, reset mid-command and error-counter saturation. A small
//   registered bank model answers bus reads.
module tb_rb_uart_bus_master;

    localparam int ADR_BITS = 8;
    localparam int TMO      = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [ADR_BITS-1:0] address;
    logic [7:0]          data_write_in;
    logic [7:0]          data_read_out;
    logic                reg_en;
    logic                write_en;
    logic                busy;
    logic [7:0]          err_cnt;

    rb_uart_bus_master #(
        .ADR_BITS       (ADR_BITS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .address       (address),
        .data_write_in (data_write_in),
        .data_read_out (data_read_out),
        .reg_en        (reg_en),
        .write_en      (write_en),
        .busy          (busy),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    // Register bank model: unwritten locations return a fixed pattern.
    logic [7:0]   mem [256];
    logic [255:0] written;
    logic [7:0]   rd_q;
    assign data_read_out = rd_q;

    function automatic logic [7:0] dflt(input logic [7:0] a);
        case (a)
            8'h01:   return 8'h85;
            8'h40:   return 8'h3C;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            written <= '0;
            rd_q    <= 8'h00;
        end else if (reg_en) begin
            rd_q <= written[address] ? mem[address] : dflt(address);
            if (write_en) begin
                mem[address]     <= data_write_in;
                written[address] <= 1'b1;
            end
        end
    end

    // Bus activity monitor.
    int reg_pulses = 0;
    int wr_pulses  = 0;
    int wen_bad    = 0;
    always @(negedge clk) begin
        if (reg_en) reg_pulses++;
        if (reg_en && write_en) wr_pulses++;
        if (write_en && !reg_en) wen_bad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Called on the negedge right after the last byte's strobe; that negedge counts as 1.
    task automatic wait_tx(output int lat);
        lat = 1;
        while (!tx_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nbytes;
        logic [7:0] exp_tx;
        int         exp_lat;
        int         exp_wr;
        int         exp_rd;
        logic [7:0] exp_err;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, r0, w0, bad;
        logic [7:0] e0;

        vecs[0] = '{8'h57, 8'h02, 8'h2A, 3, 8'h06, 2, 1, 0, 8'h00, 8'h02, 8'h2A};
        vecs[1] = '{8'h52, 8'h01, 8'h00, 2, 8'h85, 3, 0, 1, 8'h00, 8'h01, 8'h2A};
        vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1, 0, 0, 8'h01, 8'h01, 8'h2A};
        vecs[3] = '{8'h52, 8'h40, 8'h00, 2, 8'h3C, 3, 0, 1, 8'h01, 8'h40, 8'h2A};
        vecs[4] = '{8'h52, 8'h02, 8'h00, 2, 8'h2A, 3, 0, 1, 8'h01, 8'h02, 8'h2A};
        vecs[5] = '{8'h57, 8'hFF, 8'h5A, 3, 8'h06, 2, 1, 0, 8'h01, 8'hFF, 8'h5A};
        vecs[6] = '{8'h52, 8'hFF, 8'h00, 2, 8'h5A, 3, 0, 1, 8'h01, 8'hFF, 8'h5A};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 1, 0, 0, 8'h02, 8'hFF, 8'h5A};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_address", address, 0);
        chk("rst_wdata", data_write_in, 0);
        reset = 1'b0;

        // Complete frames from the table.
        for (int i = 0; i < 8; i++) begin
            r0 = reg_pulses;
            w0 = wr_pulses;
            send_byte(vecs[i].b0);
            if (vecs[i].nbytes > 1) send_byte(vecs[i].b1);
            if (vecs[i].nbytes > 2) send_byte(vecs[i].b2);
            wait_tx(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].exp_tx);
            accept();
            chk($sformatf("v%0d_tx_valid_drop", i), tx_valid, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_wr_pulses", i), wr_pulses - w0, vecs[i].exp_wr);
            chk($sformatf("v%0d_rd_pulses", i), (reg_pulses - r0) - (wr_pulses - w0), vecs[i].exp_rd);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_address", i), address, vecs[i].exp_addr);
            chk($sformatf("v%0d_wdata", i), data_write_in, vecs[i].exp_wdata);
        end

        // Timeout in GET_DATA: aborts exactly TMO cycles after entering it.
        r0 = reg_pulses;
        e0 = err_cnt;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_busy_before", busy, 1);
        @(negedge clk);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_tx_valid", tx_valid, 0);
        chk("tmo_err_cnt", err_cnt, e0 + 8'd1);
        chk("tmo_no_bus", reg_pulses - r0, 0);

        // Byte arriving in the very cycle the timeout would fire is accepted.
        w0 = wr_pulses;
        e0 = err_cnt;
        send_byte(8'h57);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h10);
        send_byte(8'h99);
        wait_tx(lat);
        chk("tmo_edge_latency", lat, 2);
        chk("tmo_edge_tx_data", tx_data, 8'h06);
        accept();
        chk("tmo_edge_wr", wr_pulses - w0, 1);
        chk("tmo_edge_addr", address, 8'h10);
        chk("tmo_edge_err", err_cnt, e0);

        // Overrun while the reply is held by the transmitter.
        r0 = reg_pulses;
        e0 = err_cnt;
        send_byte(8'h52);
        send_byte(8'h01);
        wait_tx(lat);
        chk("ovr_latency", lat, 3);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h85) bad++;
            rx_data  = 8'h52;
            rx_valid = (k == 3);
        end
        rx_valid = 1'b0;
        chk("ovr_tx_stable", bad, 0);
        chk("ovr_err_cnt", err_cnt, e0 + 8'd1);
        accept();
        chk("ovr_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("ovr_dropped", busy, 0);
        chk("ovr_one_bus_cycle", reg_pulses - r0, 1);

        // Reset in GET_DATA.
        send_byte(8'h57);
        send_byte(8'h03);
        reset = 1'b1;
        #1;
        chk("rstgd_busy", busy, 0);
        chk("rstgd_address", address, 0);
        chk("rstgd_err_cnt", err_cnt, 0);
        chk("rstgd_reg_en", reg_en, 0);
        @(negedge clk);
        reset = 1'b0;
        w0 = wr_pulses;
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h77);
        wait_tx(lat);
        chk("rstgd_next_tx", tx_data, 8'h06);
        accept();
        chk("rstgd_next_wr", wr_pulses - w0, 1);

        // Reset in SEND.
        send_byte(8'h52);
        send_byte(8'h01);
        wait_tx(lat);
        chk("rstsd_pre_tx", tx_data, 8'h85);
        reset = 1'b1;
        #1;
        chk("rstsd_tx_valid", tx_valid, 0);
        chk("rstsd_tx_data", tx_data, 0);
        chk("rstsd_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h52);
        send_byte(8'h40);
        wait_tx(lat);
        chk("rstsd_next_lat", lat, 3);
        chk("rstsd_next_tx", tx_data, 8'h3C);
        accept();

        // Error counter saturation.
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h41);
            wait_tx(lat);
            accept();
            if (i == 253) chk("sat_fe", err_cnt, 8'hFE);
        end
        chk("sat_ff", err_cnt, 8'hFF);
        chk("sat_nak", tx_data, 8'h15);

        chk("write_en_alone", wen_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
